// File: rtl/keygen_mont_mul_pipe.sv
// rtl/keygen_mont_mul_pipe.sv - six-stage Montgomery multiplier r = a*b*2^-16 mod 12289 with tag sideband
module keygen_mont_mul_pipe #(
    parameter int TAG_W = 10
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [13:0]      in_a,
    input  logic [13:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [13:0]      out_r,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [14:0] Q   = 15'd12289;
    localparam logic [15:0] Q0I = 16'd12287;

    // Single global enable: the whole pipe freezes while the output is held.
    logic ce;
    assign ce       = !out_valid || out_ready;
    assign in_ready = ce;

    // S1: operand capture
    logic             v1;
    logic [13:0]      a1, b1;
    logic [TAG_W-1:0] tag1;

    // S2: full product
    logic             v2;
    logic [27:0]      z2;
    logic [TAG_W-1:0] tag2;

    // S3: Montgomery quotient
    logic             v3;
    logic [15:0]      m3;
    logic [27:0]      z3;
    logic [TAG_W-1:0] tag3;

    // S4: quotient times modulus
    logic             v4;
    logic [29:0]      w4;
    logic [27:0]      z4;
    logic [TAG_W-1:0] tag4;

    // S5: reduced value in [0, 2Q)
    logic             v5;
    logic [14:0]      t5;
    logic [TAG_W-1:0] tag5;

    logic [27:0] z_next;
    logic [15:0] m_next;
    logic [29:0] w_next;
    logic        lo_carry;
    logic [14:0] t_next;

    assign z_next = 28'(a1) * 28'(b1);
    assign m_next = z2[15:0] * Q0I;
    assign w_next = 30'(m3) * 30'(Q);

    // z + w is a multiple of 2^16, so the low halves are either both zero or
    // sum to exactly 2^16; a nonzero low half therefore means a carry of one.
    assign lo_carry = |(z4[15:0] | w4[15:0]);
    assign t_next   = 15'(z4[27:16]) + 15'(w4[29:16]) + 15'(lo_carry);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1        <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            tag1      <= '0;
            v2        <= 1'b0;
            z2        <= '0;
            tag2      <= '0;
            v3        <= 1'b0;
            m3        <= '0;
            z3        <= '0;
            tag3      <= '0;
            v4        <= 1'b0;
            w4        <= '0;
            z4        <= '0;
            tag4      <= '0;
            v5        <= 1'b0;
            t5        <= '0;
            tag5      <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_tag   <= '0;
        end else if (ce) begin
            v1        <= in_valid;
            a1        <= in_a;
            b1        <= in_b;
            tag1      <= in_tag;

            v2        <= v1;
            z2        <= z_next;
            tag2      <= tag1;

            v3        <= v2;
            m3        <= m_next;
            z3        <= z2;
            tag3      <= tag2;

            v4        <= v3;
            w4        <= w_next;
            z4        <= z3;
            tag4      <= tag3;

            v5        <= v4;
            t5        <= t_next;
            tag5      <= tag4;

            out_valid <= v5;
            out_r     <= (t5 >= Q) ? 14'(t5 - Q) : t5[13:0];
            out_tag   <= tag5;
        end
    end

endmodule

// File: tb/tb_keygen_mont_mul_pipe.sv
// tb/tb_keygen_mont_mul_pipe.sv - randomized bench for keygen_mont_mul_pipe against a modular-arithmetic model
`timescale 1ns/1ps
module tb_keygen_mont_mul_pipe;
    localparam int TAG_W = 10;
    localparam int Q     = 12289;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [13:0]      in_a = '0;
    logic [13:0]      in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [13:0]      out_r;
    logic [TAG_W-1:0] out_tag;

    always #5 ap_clk = ~ap_clk;

    keygen_mont_mul_pipe #(.TAG_W(TAG_W)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag)
    );

    typedef struct {
        int r;
        int tag;
        int acyc;
    } exp_t;

    exp_t             expq[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc = 0;
    int               n_out = 0;
    int               rinv = 0;
    int               last_r = -1;
    bit               accepted = 1'b0;
    bit               check_lat = 1'b0;
    bit               prev_stall = 1'b0;
    logic [13:0]      prev_r = '0;
    logic [TAG_W-1:0] prev_tag = '0;
    int               sa[256];
    int               sb[256];

    // Reference: a*b*R^-1 mod q, with R^-1 = (2^16 mod q)^-1 found by search.
    function automatic int model(input int a, input int b);
        longint p;
        p = (longint'(a) * longint'(b)) % Q;
        return int'((p * longint'(rinv)) % Q);
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, then check everything the DUT shows.
    task automatic cycle(input bit v, input int a, input int b, input int tag, input bit ordy);
        exp_t e;
        @(negedge ap_clk);
        in_valid  = v;
        in_a      = 14'(a);
        in_b      = 14'(b);
        in_tag    = TAG_W'(tag);
        out_ready = ordy;
        #1;
        cyc++;
        chk(in_ready == (!out_valid || out_ready), "in_ready_eq_ce", in_ready, !out_valid || out_ready);
        if (prev_stall) begin
            chk(out_valid == 1'b1, "stall_valid_held", out_valid, 1);
            chk(out_r == prev_r, "stall_r_held", out_r, prev_r);
            chk(out_tag == prev_tag, "stall_tag_held", out_tag, prev_tag);
        end
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk(1'b0, "unexpected_output", out_tag, -1);
            end else begin
                e = expq.pop_front();
                chk(out_r == 14'(e.r), "out_r", out_r, e.r);
                chk(out_tag == TAG_W'(e.tag), "out_tag", out_tag, e.tag);
                chk(out_r < 14'(Q), "out_r_lt_q", out_r, Q);
                if (check_lat) chk(cyc - e.acyc == 6, "latency", cyc - e.acyc, 6);
            end
            last_r = int'(out_r);
            n_out++;
        end
        if (accepted) expq.push_back('{model(int'(in_a), int'(in_b)), int'(in_tag), cyc});
        prev_stall = out_valid && !out_ready;
        prev_r     = out_r;
        prev_tag   = out_tag;
    endtask

    task automatic drain(input bit random_ready);
        int budget;
        budget = 0;
        while (expq.size() != 0 && budget < 2000) begin
            cycle(1'b0, 0, 0, 0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            budget++;
        end
        chk(expq.size() == 0, "drain_timeout", expq.size(), 0);
    endtask

    task automatic run_one(input int a, input int b, input int exp, input string name);
        int start;
        check_lat = 1'b1;
        chk(model(a, b) == exp, {"model_", name}, model(a, b), exp);
        start = n_out;
        cycle(1'b1, a, b, 5, 1'b1);
        chk(accepted, {"accept_", name}, accepted, 1);
        for (int i = 0; i < 12 && n_out == start; i++) cycle(1'b0, 0, 0, 0, 1'b1);
        chk(n_out == start + 1, {"count_", name}, n_out - start, 1);
        chk(last_r == exp, name, last_r, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, idx, n, budget;
        for (int x = 1; x < Q; x++) if ((x * 4091) % Q == 1) rinv = x;

        ap_rst_n = 1'b1;
        #2 ap_rst_n = 1'b0;
        #1;
        chk(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
        chk(out_r == 14'd0, "reset_out_r", out_r, 0);
        chk(out_tag == '0, "reset_out_tag", out_tag, 0);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        cycle(1'b0, 0, 0, 0, 1'b1);
        chk(in_ready == 1'b1, "in_ready_after_reset", in_ready, 1);

        run_one(1, 10952, 4091, "r2_to_r");
        run_one(4091, 4091, 4091, "r_times_r");
        run_one(4091, 1, 1, "r_times_one");
        run_one(12288, 4091, 12288, "qm1_times_r");
        run_one(0, 9999, 0, "zero");
        run_one(16383, 16383, model(16383, 16383), "max14");
        run_one(12288, 12288, model(12288, 12288), "qm1_sq");

        // Unstalled stream: one result per cycle, six cycles after each accept.
        for (int i = 0; i < 256; i++) begin
            sa[i] = int'($urandom_range(0, 16383));
            sb[i] = int'($urandom_range(0, 16383));
        end
        check_lat = 1'b1;
        base = n_out;
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, sa[i], sb[i], i, 1'b1);
            chk(accepted, "stream_accept", accepted, 1);
        end
        drain(1'b0);
        chk(n_out - base == 256, "stream_count", n_out - base, 256);

        // Same stream under random backpressure.
        check_lat = 1'b0;
        base = n_out;
        idx = 0;
        budget = 0;
        while (idx < 256 && budget < 5000) begin
            cycle(1'b1, sa[idx], sb[idx], idx, 1'($urandom_range(0, 1)));
            if (accepted) idx++;
            budget++;
        end
        drain(1'b1);
        chk(n_out - base == 256, "bp_stream_count", n_out - base, 256);

        // Reset with four operations in flight while the output is stalled.
        for (int i = 0; i < 4; i++) cycle(1'b1, 100 + i, 200 + i, 10 + i, 1'b0);
        budget = 0;
        while (!out_valid && budget < 20) begin
            cycle(1'b0, 0, 0, 0, 1'b0);
            budget++;
        end
        cycle(1'b0, 0, 0, 0, 1'b0);
        chk(out_valid == 1'b1, "stall_before_reset", out_valid, 1);
        #2 ap_rst_n = 1'b0;
        #1;
        chk(out_valid == 1'b0, "midreset_out_valid", out_valid, 0);
        chk(out_r == 14'd0, "midreset_out_r", out_r, 0);
        expq.delete();
        prev_stall = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        base = n_out;
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, 0, 0, 1'b1);
        chk(n_out == base, "no_stale_after_reset", n_out - base, 0);
        run_one(1, 10952, 4091, "after_reset");

        // Random regression with random bubbles and stalls.
        check_lat = 1'b0;
        base = n_out;
        n = 0;
        budget = 0;
        while (n < 20000 && budget < 60000) begin
            int a, b;
            case ($urandom_range(0, 15))
                0:       a = 16383;
                1:       a = 12288;
                default: a = int'($urandom_range(0, 16383));
            endcase
            b = ($urandom_range(0, 15) == 0) ? 16383 : int'($urandom_range(0, 16383));
            cycle($urandom_range(0, 3) != 0, a, b, int'($urandom_range(0, 1023)),
                  $urandom_range(0, 9) < 6);
            if (accepted) n++;
            budget++;
        end
        drain(1'b1);
        chk(n_out - base == 20000, "regression_count", n_out - base, 20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
